// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: generates sequential fetch PCs, issues I-cache
// requests under a credit limit, queues returned words with their PC and hands
// them in order to the decoder. A redirect flushes the queue, drops stale
// in-flight responses and restarts fetch at the new PC.
module inst_fetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter logic [31:0] RESET_PC     = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ins,
    output logic        out_exc
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned SW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [31:0]   pc;
    logic          halted;
    logic [IW-1:0] inflight;
    logic [IW-1:0] discard;

    logic [31:0]   q_pc  [DEPTH];
    logic [31:0]   q_ins [DEPTH];
    logic          q_exc [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    // PC of each accepted request, retired in order as responses come back
    logic [31:0]   sh_pc [MAX_INFLIGHT];
    logic [SW-1:0] sh_wr;
    logic [SW-1:0] sh_rd;

    logic          fire;
    logic          pop;
    logic          push_word;
    logic          push_exc;
    logic          push;
    logic [31:0]   push_pc;
    logic [31:0]   push_ins;
    logic [31:0]   occupancy;

    function automatic logic [SW-1:0] sh_next(input logic [SW-1:0] p);
        return (32'(p) == MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
    endfunction

    // Request credit, queue push/pop decisions and misaligned-PC exception entry
    always_comb begin
        // words already queued plus words still owed by the cache that will be kept
        occupancy = 32'(count) + 32'(inflight) - 32'(discard);
        inst_req  = resetn && !redirect_valid && !halted && (pc[1:0] == 2'b00)
                    && (32'(inflight) < MAX_INFLIGHT) && (occupancy < DEPTH);
        fire      = inst_req && inst_addr_ok;
        pop       = out_valid && out_ready && !redirect_valid;
        push_word = inst_data_ok && !redirect_valid && (discard == '0);
        // inflight==discard means every older kept word is already in the queue,
        // so the exception entry lands behind them and cannot collide with a data push
        push_exc  = !redirect_valid && !halted && (pc[1:0] != 2'b00)
                    && (inflight == discard) && (32'(count) != DEPTH);
        push      = push_word || push_exc;
        push_pc   = push_exc ? pc  : sh_pc[sh_rd];
        push_ins  = push_exc ? '0  : inst_rdata;
    end

    // Head-of-queue presentation toward the decoder
    always_comb begin
        inst_addr = pc;
        out_valid = (count != '0);
        out_pc    = q_pc[head];
        out_ins   = q_ins[head];
        out_exc   = out_valid && q_exc[head];
    end

    // Fetch PC, credit counters, shadow PC FIFO and instruction queue state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc       <= RESET_PC;
            halted   <= 1'b0;
            inflight <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            sh_wr    <= '0;
            sh_rd    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_exc[i] <= 1'b0;
            end
        end else begin
            case ({fire, inst_data_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            if (fire) begin
                sh_pc[sh_wr] <= pc;
                sh_wr        <= sh_next(sh_wr);
                pc           <= pc + 32'd4;
            end
            if (inst_data_ok) begin
                sh_rd <= sh_next(sh_rd);
            end

            if (redirect_valid) begin
                // shadow FIFO is left intact so stale responses still retire their PCs
                pc      <= redirect_pc;
                halted  <= 1'b0;
                discard <= inflight - IW'(inst_data_ok);
                count   <= '0;
                head    <= tail;
            end else begin
                if (inst_data_ok && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push_exc) begin
                    halted <= 1'b1;
                end
                if (push) begin
                    q_pc[tail]  <= push_pc;
                    q_ins[tail] <= push_ins;
                    q_exc[tail] <= push_exc;
                    tail        <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    no_data_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_data_ok && (inflight == '0)));

    no_push_on_full: assert property (@(posedge clk) disable iff (!resetn)
        !(push && (32'(count) == DEPTH)));

endmodule
